wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Parametrised writeback arbiter between the functional units (AluMisc, Mem, Mult and any added later) and the single register-file write port. Each functional-unit channel gets its own small result FIFO with a valid/ready handshake, so a unit is never forced to drop or overwrite a result when several units finish in the same cycle. It drains at most one entry per cycle into a registered `wb_reg_*` write port, using fixed-priority or round-robin selection. It supersedes the fixed three-input Writeback stage and has a configurable channel count, buffer depth and arbitration mode.

## Interface

- `CHANNELS`, 3: number of functional-unit channels, 2..8.
- `DEPTH`, 2: entries per channel FIFO, power of two, ≥2.
- `RR_MODE`, 1: 1 selects round-robin; 0 selects fixed priority, lowest index wins.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fu_wb_valid`  in  CHANNELS  channel i presents a result.
- `fu_wb_regdest`  in  5*CHANNELS  destination register; channel i occupies bits [5i+4:5i].
- `fu_wb_writereg`  in  CHANNELS  result must write the register file.
- `fu_wb_wbvalue`  in  32*CHANNELS  result data; channel i occupies bits [32i+31:32i].
- `wb_fu_ready`  out  CHANNELS  channel i can accept an entry this cycle.
- `wb_reg_en`  out  1  register-file write enable (registered).
- `wb_reg_addr`  out  5  write address (registered).
- `wb_reg_data`  out  32  write data (registered).
- `wb_grant`  out  CHANNELS  one-hot, registered; identifies the channel drained in the previous cycle.

## Operation

- **FIFO entries:** each channel has a FIFO of DEPTH entries, each `{regdest, writereg, wbvalue}`. Read and write pointers wrap modulo DEPTH. Count width is clog2(DEPTH+1).
- **Ready:** `wb_fu_ready[i] = (count[i] != DEPTH)`. It is a function of state only and has no combinational path from `fu_wb_valid`.
- **Push:** channel i pushes when `fu_wb_valid[i] && wb_fu_ready[i]`. A full channel does not accept, even in a cycle where it is being popped.
- **Arbitration:** each cycle, one non-empty channel is selected and its head entry is popped.
  - RR_MODE=1: search starts at pointer `rr_ptr`. After a grant to channel i, `rr_ptr <= (i+1) mod CHANNELS`. `rr_ptr` is unchanged when nothing is granted.
  - RR_MODE=0: lowest-index non-empty channel wins. `rr_ptr` is unused.
- **Output register update:**
  - On a grant to channel i: `wb_grant <= 1<<i`, `wb_reg_addr <= regdest`, `wb_reg_data <= wbvalue`, `wb_reg_en <= writereg && (regdest != 0)`.
  - An entry with writereg=0 or regdest=0 still consumes the slot and asserts `wb_grant`, but produces no write.
  - With no grant: `wb_reg_en <= 0` and `wb_grant <= 0`; `wb_reg_addr` and `wb_reg_data` hold their values.
- **Push and pop in the same cycle** on one channel: count is unchanged and both pointers advance.
- **Ordering:** entries from one channel retire in FIFO order. No ordering is guaranteed across channels; WAW hazards remain the issue stage's responsibility.
- **Reset (`reset`=0, asynchronous):**
  - All counts and pointers go to 0 and `rr_ptr` goes to 0.
  - `wb_reg_en`=0, `wb_reg_addr`=0, `wb_reg_data`=0, `wb_grant`=0, and `wb_fu_ready` is all ones.
  - Entries queued when reset asserts mid-operation are discarded. No write occurs on the first edge after release unless an entry was pushed at that edge, and even then the write appears one edge later.

## Timing

- **Latency:** an entry accepted at rising edge E0 into an empty channel that wins arbitration appears on `wb_reg_*` and `wb_grant` after edge E1.
- **Throughput:** one writeback per cycle aggregate, and at most one pop per channel per cycle.
- **Round-robin fairness:** a non-empty channel is granted within CHANNELS cycles.
- **Fixed-priority mode:** channel 0 can starve higher-index channels indefinitely. Their `wb_fu_ready` falls once their FIFO is full.
- **Ready release:** `wb_fu_ready[i]` rises the cycle after a pop of a full channel i.

## Test plan

1. **Reset values:** assert `reset`=0 with random inputs, then release → all outputs 0, `wb_fu_ready`=3'b111, no `wb_reg_en` for 5 idle cycles.
2. **Single write:** ch1 presents regdest=5, value 0xDEADBEEF, writereg=1 for one cycle → one edge later `wb_reg_en`=1, addr=5, data=0xDEADBEEF, `wb_grant`=3'b010; next cycle `wb_reg_en`=0.
3. **Round-robin order:** RR_MODE=1; after test 2 (`rr_ptr`=2), all three channels push in the same cycle with regdest 1/2/3 → writes on consecutive cycles to r3, r1, r2 with grants 100, 001, 010.
4. **Backpressure:** RR_MODE=0, DEPTH=2; ch0 valid every cycle and ch1 pushes 3 entries → `wb_fu_ready[1]` drops after 2 accepts; ch1 entries are granted only after ch0 stops, in push order, and the third is accepted the cycle after the first ch1 pop.
5. **Suppressed writes:** entry with writereg=0, regdest=7, and an entry with writereg=1, regdest=0 → `wb_grant` asserted for each, `wb_reg_en`=0 both times, FIFO drained.
6. **Reset mid-operation:** three entries queued on each channel, then assert reset mid-cycle → outputs clear immediately; after release, no `wb_reg_en` without new pushes.

Source files
------------

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter between N functional-unit result channels and the single
// register-file write port. Every channel owns a small FIFO, so units that
// finish in the same cycle never lose a result. At most one entry is drained
// per cycle, chosen by round-robin (RR_MODE=1) or fixed priority with the
// lowest index winning (RR_MODE=0). The drained entry is registered onto the
// wb_reg_* port together with a one-hot wb_grant naming its channel.
//
// Parameters
//   CHANNELS  number of functional-unit channels (2..8)
//   DEPTH     entries per channel FIFO (power of two, >= 2)
//   RR_MODE   1 = round-robin, 0 = fixed priority
//
// Ports
//   clock           sole clock, rising edge
//   reset           asynchronous, active-low reset
//   fu_wb_valid     [CHANNELS]     channel i presents a result
//   fu_wb_regdest   [5*CHANNELS]   destination register, channel i at [5i+4:5i]
//   fu_wb_writereg  [CHANNELS]     result must write the register file
//   fu_wb_wbvalue   [32*CHANNELS]  result data, channel i at [32i+31:32i]
//   wb_fu_ready     [CHANNELS]     channel i can accept an entry this cycle
//   wb_reg_en                      register-file write enable (registered)
//   wb_reg_addr     [5]            write address (registered)
//   wb_reg_data     [32]           write data (registered)
//   wb_grant        [CHANNELS]     one-hot, channel drained in previous cycle
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 2,
  parameter int RR_MODE  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      fu_wb_valid,
  input  logic [5*CHANNELS-1:0]    fu_wb_regdest,
  input  logic [CHANNELS-1:0]      fu_wb_writereg,
  input  logic [32*CHANNELS-1:0]   fu_wb_wbvalue,
  output logic [CHANNELS-1:0]      wb_fu_ready,
  output logic                     wb_reg_en,
  output logic [4:0]               wb_reg_addr,
  output logic [31:0]              wb_reg_data,
  output logic [CHANNELS-1:0]      wb_grant
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CH_W  = $clog2(CHANNELS);

  typedef struct packed {
    logic [4:0]  regdest;
    logic        writereg;
    logic [31:0] wbvalue;
  } entry_t;

  // FIFO storage and bookkeeping
  entry_t            mem_q    [CHANNELS][DEPTH];
  entry_t            in_entry [CHANNELS];
  logic [PTR_W-1:0]  wr_ptr_q [CHANNELS];
  logic [PTR_W-1:0]  wr_ptr_d [CHANNELS];
  logic [PTR_W-1:0]  rd_ptr_q [CHANNELS];
  logic [PTR_W-1:0]  rd_ptr_d [CHANNELS];
  logic [CNT_W-1:0]  count_q  [CHANNELS];
  logic [CNT_W-1:0]  count_d  [CHANNELS];

  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] nonempty;

  // Arbitration
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              gnt_valid;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W:0]     cand_sum;
  logic [CH_W-1:0]   cand;
  entry_t            head;

  // Output registers
  logic                wb_reg_en_q;
  logic [4:0]          wb_reg_addr_q;
  logic [31:0]         wb_reg_data_q;
  logic [CHANNELS-1:0] wb_grant_q;

  // Ready depends on stored count only, so there is no combinational path from
  // fu_wb_valid to wb_fu_ready. A full channel refuses even while being popped.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    wb_fu_ready = '0;
    push        = '0;
    nonempty    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wb_fu_ready[i] = (count_q[i] != CNT_W'(DEPTH));
      push[i]        = fu_wb_valid[i] & wb_fu_ready[i];
      nonempty[i]    = (count_q[i] != '0);
      in_entry[i]    = '{regdest:  fu_wb_regdest[5*i +: 5],
                         writereg: fu_wb_writereg[i],
                         wbvalue:  fu_wb_wbvalue[32*i +: 32]};
    end
  end

  // Channel selection. In round-robin mode the candidates are visited from the
  // farthest offset back to rr_ptr itself, so the nearest non-empty channel at
  // or after rr_ptr is the last one written and therefore wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    if (RR_MODE != 0) begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        cand_sum = {1'b0, rr_ptr_q} + (CH_W + 1)'(k);
        if (cand_sum >= (CH_W + 1)'(CHANNELS)) begin
          cand_sum = cand_sum - (CH_W + 1)'(CHANNELS);
        end
        cand = cand_sum[CH_W-1:0];
        if (nonempty[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end else begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (nonempty[i]) begin
          gnt_valid = 1'b1;
          gnt_idx   = CH_W'(i);
        end
      end
    end
  end

  always_comb begin
    pop  = '0;
    head = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
    for (int i = 0; i < CHANNELS; i++) begin
      pop[i] = gnt_valid && (gnt_idx == CH_W'(i));
    end

    rr_ptr_d = rr_ptr_q;
    if (RR_MODE != 0 && gnt_valid) begin
      rr_ptr_d = (gnt_idx == CH_W'(CHANNELS - 1)) ? '0 : gnt_idx + CH_W'(1);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    for (int i = 0; i < CHANNELS; i++) begin
      wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push[i] && !pop[i]) begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end else if (!push[i] && pop[i]) begin
        count_d[i] = count_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // NOTE: FIFO storage carries no reset; an entry is only ever read while the
  // channel count says it is valid, so clearing the array would buy nothing.
  always_ff @(posedge clock) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_entry[i];
      end
    end
  end

  // Register-file port. Entries with writereg=0 or regdest=0 still take the
  // slot and raise wb_grant, but never enable a write (r0 is hardwired).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_reg_en_q   <= 1'b0;
      wb_reg_addr_q <= '0;
      wb_reg_data_q <= '0;
      wb_grant_q    <= '0;
    end else if (gnt_valid) begin
      wb_reg_en_q   <= head.writereg && (head.regdest != 5'd0);
      wb_reg_addr_q <= head.regdest;
      wb_reg_data_q <= head.wbvalue;
      wb_grant_q    <= CHANNELS'(1) << gnt_idx;
    end else begin
      wb_reg_en_q   <= 1'b0;
      wb_grant_q    <= '0;
    end
  end

  assign wb_reg_en   = wb_reg_en_q;
  assign wb_reg_addr = wb_reg_addr_q;
  assign wb_reg_data = wb_reg_data_q;
  assign wb_grant    = wb_grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed bench for wb_arbiter. Two instances share clock and reset: u_rr in
// round-robin mode and u_fp in fixed-priority mode, both with three channels
// of depth two. Every accepted entry is pushed onto a per-instance scoreboard
// when it is driven; a negedge monitor pops the oldest entry of the granted
// channel and compares it, which checks per-channel order and payload. Cross-
// channel order and cycle timing are checked inline by the directed steps.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int CH    = 3;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [1:0]  ch;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Round-robin instance
  logic [CH-1:0]    rr_valid, rr_writereg, rr_ready, rr_grant;
  logic [4:0]       rr_rd  [CH];
  logic [31:0]      rr_val [CH];
  logic [5*CH-1:0]  rr_regdest;
  logic [32*CH-1:0] rr_wbvalue;
  logic             rr_en;
  logic [4:0]       rr_addr;
  logic [31:0]      rr_data;

  // Fixed-priority instance
  logic [CH-1:0]    fp_valid, fp_writereg, fp_ready, fp_grant;
  logic [4:0]       fp_rd  [CH];
  logic [31:0]      fp_val [CH];
  logic [5*CH-1:0]  fp_regdest;
  logic [32*CH-1:0] fp_wbvalue;
  logic             fp_en;
  logic [4:0]       fp_addr;
  logic [31:0]      fp_data;

  assign rr_regdest = {rr_rd[2], rr_rd[1], rr_rd[0]};
  assign rr_wbvalue = {rr_val[2], rr_val[1], rr_val[0]};
  assign fp_regdest = {fp_rd[2], fp_rd[1], fp_rd[0]};
  assign fp_wbvalue = {fp_val[2], fp_val[1], fp_val[0]};

  wb_arbiter #(.CHANNELS(CH), .DEPTH(DEPTH), .RR_MODE(1)) u_rr (
    .clock          (clock),
    .reset          (reset),
    .fu_wb_valid    (rr_valid),
    .fu_wb_regdest  (rr_regdest),
    .fu_wb_writereg (rr_writereg),
    .fu_wb_wbvalue  (rr_wbvalue),
    .wb_fu_ready    (rr_ready),
    .wb_reg_en      (rr_en),
    .wb_reg_addr    (rr_addr),
    .wb_reg_data    (rr_data),
    .wb_grant       (rr_grant)
  );

  wb_arbiter #(.CHANNELS(CH), .DEPTH(DEPTH), .RR_MODE(0)) u_fp (
    .clock          (clock),
    .reset          (reset),
    .fu_wb_valid    (fp_valid),
    .fu_wb_regdest  (fp_regdest),
    .fu_wb_writereg (fp_writereg),
    .fu_wb_wbvalue  (fp_wbvalue),
    .wb_fu_ready    (fp_ready),
    .wb_reg_en      (fp_en),
    .wb_reg_addr    (fp_addr),
    .wb_reg_data    (fp_data),
    .wb_grant       (fp_grant)
  );

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   fail_cnt  = 0;
  bit   sb_en     = 1'b0;
  exp_t rr_sb [$];
  exp_t fp_sb [$];

  // Expected round-robin order after the single write left rr_ptr at 2.
  logic [2:0] t3_grant [3] = '{3'b100, 3'b001, 3'b010};
  logic [4:0] t3_addr  [3] = '{5'd3, 5'd1, 5'd2};
  // Backpressure step: expected fp grant and ready[1] after edges E1..E9.
  logic [2:0] t4_grant [9] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001,
                               3'b010, 3'b010, 3'b010, 3'b000};
  logic       t4_rdy1  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one entry on a channel and record what it must produce.
  task automatic drive(input int d, input logic [1:0] ch, input logic [4:0] rd,
                       input logic wr, input logic [31:0] val);
    exp_t e;
    e.ch   = ch;
    e.en   = wr && (rd != 5'd0);
    e.addr = rd;
    e.data = val;
    if (d == 0) begin
      rr_valid[ch] = 1'b1; rr_rd[ch] = rd; rr_writereg[ch] = wr; rr_val[ch] = val;
      rr_sb.push_back(e);
    end else begin
      fp_valid[ch] = 1'b1; fp_rd[ch] = rd; fp_writereg[ch] = wr; fp_val[ch] = val;
      fp_sb.push_back(e);
    end
  endtask

  task automatic release_ch(input int d, input logic [1:0] ch);
    if (d == 0) rr_valid[ch] = 1'b0;
    else        fp_valid[ch] = 1'b0;
  endtask

  task automatic sb_pop(input int d, input logic [1:0] ch, output exp_t e, output bit found);
    found = 1'b0;
    e     = '0;
    if (d == 0) begin
      for (int i = 0; i < rr_sb.size(); i++) begin
        if (rr_sb[i].ch == ch) begin
          e = rr_sb[i]; rr_sb.delete(i); found = 1'b1; break;
        end
      end
    end else begin
      for (int i = 0; i < fp_sb.size(); i++) begin
        if (fp_sb[i].ch == ch) begin
          e = fp_sb[i]; fp_sb.delete(i); found = 1'b1; break;
        end
      end
    end
  endtask

  task automatic sb_mon(input int d, input string nm, input logic [CH-1:0] g,
                        input logic en, input logic [4:0] a, input logic [31:0] v);
    exp_t       e;
    bit         found;
    logic [1:0] ch;
    if (g == '0) return;
    check({nm, "_grant_onehot"}, 32'($onehot(g)), 1);
    ch = '0;
    for (int i = 0; i < CH; i++) if (g[i]) ch = 2'(i);
    sb_pop(d, ch, e, found);
    check({nm, "_sb_expected_entry"}, 32'(found), 1);
    if (found) begin
      check({nm, "_sb_en"},   32'(en), 32'(e.en));
      check({nm, "_sb_addr"}, 32'(a),  32'(e.addr));
      check({nm, "_sb_data"}, v,       e.data);
    end
  endtask

  always @(negedge clock) begin
    if (reset && sb_en) begin
      sb_mon(0, "rr", rr_grant, rr_en, rr_addr, rr_data);
      sb_mon(1, "fp", fp_grant, fp_en, fp_addr, fp_data);
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_rr_en"},    32'(rr_en),    0);
    check({tag, "_rr_grant"}, 32'(rr_grant), 0);
    check({tag, "_fp_en"},    32'(fp_en),    0);
    check({tag, "_fp_grant"}, 32'(fp_grant), 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rr_addr"},  32'(rr_addr),  0);
    check({tag, "_rr_data"},  rr_data,       0);
    check({tag, "_rr_ready"}, 32'(rr_ready), 32'h7);
    check({tag, "_fp_addr"},  32'(fp_addr),  0);
    check({tag, "_fp_data"},  fp_data,       0);
    check({tag, "_fp_ready"}, 32'(fp_ready), 32'h7);
    check_idle(tag);
  endtask

  initial begin
    rr_valid = '0; rr_writereg = '0; fp_valid = '0; fp_writereg = '0;
    for (int c = 0; c < CH; c++) begin
      rr_rd[c] = '0; rr_val[c] = '0; fp_rd[c] = '0; fp_val[c] = '0;
    end

    // 1. Reset with random inputs, then five idle cycles.
    #2 reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      rr_valid = CH'($urandom); rr_writereg = CH'($urandom);
      fp_valid = CH'($urandom); fp_writereg = CH'($urandom);
      for (int c = 0; c < CH; c++) begin
        rr_rd[c] = 5'($urandom); rr_val[c] = $urandom;
        fp_rd[c] = 5'($urandom); fp_val[c] = $urandom;
      end
      #7;
    end
    check_cleared("t1_in_reset");
    rr_valid = '0; fp_valid = '0;
    @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check_idle("t1_idle");
    end
    sb_en = 1'b1;

    // 2. Single write on channel 1, visible one edge after acceptance.
    drive(0, 2'd1, 5'd5, 1'b1, 32'hDEADBEEF);
    tick();
    release_ch(0, 2'd1);
    tick();
    check("t2_en",    32'(rr_en),    1);
    check("t2_addr",  32'(rr_addr),  5);
    check("t2_data",  rr_data,       32'hDEADBEEF);
    check("t2_grant", 32'(rr_grant), 32'b010);
    tick();
    check("t2_en_off",    32'(rr_en),    0);
    check("t2_grant_off", 32'(rr_grant), 0);

    // 3. Round-robin: all three push together, search resumes at channel 2.
    drive(0, 2'd0, 5'd1, 1'b1, 32'h1111_0001);
    drive(0, 2'd1, 5'd2, 1'b1, 32'h2222_0002);
    drive(0, 2'd2, 5'd3, 1'b1, 32'h3333_0003);
    tick();
    rr_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_grant", 32'(rr_grant), 32'(t3_grant[k]));
      check("t3_addr",  32'(rr_addr),  32'(t3_addr[k]));
      check("t3_en",    32'(rr_en),    1);
    end
    tick();
    check("t3_idle_grant", 32'(rr_grant), 0);

    // 4. Fixed priority with backpressure: ch0 streams four entries, ch1
    //    offers three and stalls until ch0 goes quiet.
    for (int s = 0; s < 9; s++) begin
      if (s < 4) drive(1, 2'd0, 5'(s + 8), 1'b1, 32'hA000_0000 + s);
      else       release_ch(1, 2'd0);
      if (s < 3)       drive(1, 2'd1, 5'(s + 16), 1'b1, 32'hB000_0000 + s);
      else if (s == 7) release_ch(1, 2'd1);
      tick();
      check("t4_grant",  32'(fp_grant),    32'(t4_grant[s]));
      check("t4_ready1", 32'(fp_ready[1]), 32'(t4_rdy1[s]));
    end

    // 5. Suppressed writes: writereg=0 to r7, then writereg=1 to r0.
    drive(1, 2'd2, 5'd7, 1'b0, 32'h5555_5555);
    tick();
    drive(1, 2'd2, 5'd0, 1'b1, 32'h6666_6666);
    tick();
    release_ch(1, 2'd2);
    check("t5a_grant", 32'(fp_grant), 32'b100);
    check("t5a_en",    32'(fp_en),    0);
    check("t5a_addr",  32'(fp_addr),  7);
    tick();
    check("t5b_grant", 32'(fp_grant), 32'b100);
    check("t5b_en",    32'(fp_en),    0);
    check("t5b_addr",  32'(fp_addr),  0);
    tick();
    check("t5_drained_grant", 32'(fp_grant), 0);
    check("t5_drained_ready", 32'(fp_ready), 32'h7);

    // 6. Reset mid-operation with every channel loaded.
    tick();
    sb_en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      rr_valid = '1; fp_valid = '1; rr_writereg = '1; fp_writereg = '1;
      for (int c = 0; c < CH; c++) begin
        rr_rd[c] = 5'(c + 20); rr_val[c] = 32'hC000_0000 + n * 4 + c;
        fp_rd[c] = 5'(c + 24); fp_val[c] = 32'hD000_0000 + n * 4 + c;
      end
      tick();
    end
    rr_valid = '0; fp_valid = '0;
    check("t6_busy_rr_en", 32'(rr_en), 1);
    check("t6_busy_fp_en", 32'(fp_en), 1);
    #3 reset = 1'b0;
    #1;
    check_cleared("t6_in_reset");
    tick();
    @(negedge clock);
    reset = 1'b1;
    rr_sb.delete();
    fp_sb.delete();
    for (int n = 0; n < 5; n++) begin
      tick();
      check_idle("t6_idle");
    end
    check("t6_ready_rr", 32'(rr_ready), 32'h7);
    sb_en = 1'b1;

    // rr_ptr restarted at 0, so a three-way push drains 0, 1, 2.
    drive(0, 2'd0, 5'd9,  1'b1, 32'hE000_0000);
    drive(0, 2'd1, 5'd10, 1'b1, 32'hE000_0001);
    drive(0, 2'd2, 5'd11, 1'b1, 32'hE000_0002);
    tick();
    rr_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_rr_grant", 32'(rr_grant), 32'(1 << k));
    end
    tick();
    tick();
    check("end_rr_sb_empty", 32'(rr_sb.size()), 0);
    check("end_fp_sb_empty", 32'(fp_sb.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
